// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants for receiver, rx buffer and transmitter
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int CLKPERBAUD  = 1041;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO
// Head entry is presented combinationally; a write is visible the next cycle.
module sync_fifo_fwft
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = UART_DATA_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - captures received UART bytes into a FWFT FIFO
// Adds receiver edge detection, rec_ready throttling and a sticky overflow flag.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   rx_ready_in,
    input  logic [UART_DATA_W-1:0] rx_byte_in,
    output logic                   rec_ready_out,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_valid,
    input  logic                   rd_en,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow,
    input  logic                   clear_ovf
);

    logic rx_ready_q, rx_ready_d;
    logic overflow_q, overflow_d;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic ovf_event;

    // The byte is only valid on the rising edge of rx_ready_in; later cycles read zero.
    assign push = rx_ready_in & ~rx_ready_q;
    assign pop  = rd_en & rd_valid;

    sync_fifo_fwft #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .nRst  (nRst),
        .push  (push),
        .wdata (rx_byte_in),
        .pop   (pop),
        .rdata (rd_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid      = ~fifo_empty;
    assign rec_ready_out = ~fifo_full;
    assign overflow      = overflow_q;
    assign ovf_event     = push & fifo_full & ~pop;

    always_comb begin
        rx_ready_d = rx_ready_in;
        overflow_d = overflow_q;
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // rx_ready_q resets high so leaving reset mid stop bit does not look like an edge.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_ready_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer
module tb_uart_rx_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic             rx_ready_in = 1'b0;
    logic [7:0]       rx_byte_in = 8'h00;
    logic             rec_ready_out;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_en = 1'b0;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clear_ovf = 1'b0;

    uart_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .nRst          (nRst),
        .rx_ready_in   (rx_ready_in),
        .rx_byte_in    (rx_byte_in),
        .rec_ready_out (rec_ready_out),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_en         (rd_en),
        .count         (count),
        .overflow      (overflow),
        .clear_ovf     (clear_ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: byte-level view of the buffer.
    logic [7:0] exp_q[$];
    int  model_cnt = 0;
    bit  model_ovf = 1'b0;
    bit  model_prev = 1'b1;
    bit  started = 1'b0;
    int  ovf_events = 0;

    always @(posedge clk) begin
        bit rise, take, accept;
        if (!nRst) begin
            model_cnt  = 0;
            model_ovf  = 1'b0;
            model_prev = 1'b1;
            exp_q.delete();
            started    = 1'b1;
        end else begin
            rise   = rx_ready_in && !model_prev;
            take   = rd_en && (model_cnt != 0);
            accept = rise && (model_cnt < DEPTH || take);
            if (accept) exp_q.push_back(rx_byte_in);
            if (rise && !accept) begin
                model_ovf = 1'b1;
                ovf_events++;
            end else if (clear_ovf) begin
                model_ovf = 1'b0;
            end
            model_cnt  = model_cnt + int'(accept) - int'(take);
            model_prev = rx_ready_in;
        end
    end

    // Monitor: state comparison every cycle, data comparison on every pop.
    always @(negedge clk) begin
        if (started) begin
            check("count", int'(count), model_cnt);
            check("rd_valid", int'(rd_valid), int'(model_cnt != 0));
            check("rec_ready_out", int'(rec_ready_out), int'(model_cnt < DEPTH));
            check("overflow", int'(overflow), int'(model_ovf));
            if (rd_en && rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_scoreboard", 1, 0);
                end else begin
                    check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        rx_ready_in = 1'b1;
        rx_byte_in  = b;
        tick();
        rx_byte_in  = 8'h00;
        repeat (hold) tick();
        rx_ready_in = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset with receiver mid stop bit, release without a new edge.
        nRst = 1'b0;
        rx_ready_in = 1'b1;
        rx_byte_in = 8'hAA;
        tick();
        tick();
        nRst = 1'b1;
        rx_byte_in = 8'h00;
        repeat (4) tick();
        check("reset_no_capture", int'(count), 0);
        rx_ready_in = 1'b0;
        tick();

        // Single byte with a full-length stop bit.
        send(8'h5A, 1040);
        check("single_count", int'(count), 1);
        check("single_data", int'(rd_data), 8'h5A);
        pop_n(1);
        check("single_drained", int'(rd_valid), 0);

        // Fill, partial drain, refill across the pointer wrap.
        for (int i = 1; i <= DEPTH; i++) send(8'(i), 2);
        check("full_count", int'(count), DEPTH);
        check("full_rec_ready", int'(rec_ready_out), 0);
        pop_n(3);
        for (int i = 9; i <= 11; i++) send(8'(i), 2);
        check("wrap_head", int'(rd_data), 8'h04);

        // Overflow while full, then clear.
        send(8'hFF, 2);
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(count), DEPTH);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Push and pop in the same cycle at full.
        rx_ready_in = 1'b1;
        rx_byte_in  = 8'hC3;
        rd_en       = 1'b1;
        tick();
        rd_en       = 1'b0;
        rx_byte_in  = 8'h00;
        tick();
        rx_ready_in = 1'b0;
        tick();
        check("simul_count", int'(count), DEPTH);
        check("simul_ovf", int'(overflow), 0);
        pop_n(DEPTH);
        check("drained", int'(count), 0);

        // Set beats clear in the same cycle.
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1);
        rx_ready_in = 1'b1;
        rx_byte_in  = 8'hEE;
        clear_ovf   = 1'b1;
        tick();
        clear_ovf   = 1'b0;
        rx_byte_in  = 8'h00;
        rx_ready_in = 1'b0;
        tick();
        check("set_wins", int'(overflow), 1);

        // Random traffic obeying the receiver's byte/strobe contract.
        for (int c = 0; c < 3000; c++) begin
            if (!rx_ready_in) begin
                if ($urandom_range(2) == 0) begin
                    rx_ready_in = 1'b1;
                    rx_byte_in  = 8'($urandom);
                end
            end else begin
                rx_byte_in = 8'h00;
                if ($urandom_range(2) == 0) rx_ready_in = 1'b0;
            end
            rd_en     = ($urandom_range(3) == 0);
            clear_ovf = ($urandom_range(15) == 0);
            if (c == 1500) nRst = 1'b0;
            if (c == 1502) nRst = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        clear_ovf = 1'b0;
        rx_ready_in = 1'b0;
        tick();
        pop_n(DEPTH + 1);
        check("final_empty", int'(rd_valid), 0);
        check("ovf_exercised", int'(ovf_events > 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
